// File: rtl/sparse_match_sched_pkg.sv
// Shared types and width helpers for the sparse bitmap match scheduler.
// Contents: scheduler state enum, index/chunk/count width functions.
package sparse_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SCAN,
        DONE
    } sched_state_e;

    function automatic int idx_w(input int size);
        return $clog2(size);
    endfunction

    function automatic int chk_w(input int num_chunk);
        return $clog2(num_chunk);
    endfunction

    // Wide enough to hold the all-bits-set count SIZE*NUM_CHUNK.
    function automatic int cnt_w(input int size, input int num_chunk);
        return $clog2(size * num_chunk + 1);
    endfunction

endpackage

// File: rtl/sparse_match_sched_if.sv
// Chunk-in / match-out bus of the sparse match scheduler.
// Chunk channel : chunk_valid_i, chunk_ready_o, in1_i (IFM), in2_i (filter).
// Match channel : match_valid_o, match_ready_i, match_addr_o {chunk,bit}, match_last_o.
// Signal suffixes are from the scheduler's point of view.
// Modport slave = scheduler side, master = fetch unit / address generator side.
interface sparse_match_sched_if
    import sparse_sched_pkg::*;
#(
    parameter int SIZE      = 128,
    parameter int NUM_CHUNK = 4
) ();
    localparam int ADDR_W = chk_w(NUM_CHUNK) + idx_w(SIZE);

    logic              chunk_valid_i;
    logic              chunk_ready_o;
    logic [SIZE-1:0]   in1_i;
    logic [SIZE-1:0]   in2_i;
    logic              match_valid_o;
    logic              match_ready_i;
    logic [ADDR_W-1:0] match_addr_o;
    logic              match_last_o;

    modport slave (
        input  chunk_valid_i, in1_i, in2_i, match_ready_i,
        output chunk_ready_o, match_valid_o, match_addr_o, match_last_o
    );

    modport master (
        output chunk_valid_i, in1_i, in2_i, match_ready_i,
        input  chunk_ready_o, match_valid_o, match_addr_o, match_last_o
    );
endinterface

// File: rtl/sparse_match_sched_lsb_find.sv
// Combinational lowest-set-bit finder for one bitmap chunk.
// Ports: vec_i (SIZE) in; idx_o lowest set index; any_o some bit set;
//        one_o exactly one bit set.
module sparse_lsb_find
    import sparse_sched_pkg::*;
#(
    parameter  int SIZE  = 128,
    localparam int IDX_W = idx_w(SIZE)
) (
    input  logic [SIZE-1:0]  vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o,
    output logic             one_o
);
    logic found;

    always_comb begin
        idx_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (vec_i[i] && !found) begin
                idx_o = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

    assign any_o = |vec_i;
    // x & (x-1) clears the lowest set bit; zero afterwards means a single bit.
    assign one_o = any_o && ((vec_i & (vec_i - SIZE'(1))) == '0);

endmodule

// File: rtl/sparse_match_sched.sv
// Job-level scheduler for the sparse IFM/filter bitmap match datapath.
// Loads NUM_CHUNK chunk pairs per job, ANDs each pair and emits every set
// bit as {chunk_idx, bit_idx}, lowest first, one per cycle under backpressure.
// Ports: clk_i, rst_ni (async active-low), start_i, flush_i (sync abort),
//        bus (sparse_match_sched_if.slave), busy_o, done_o (1-cycle pulse).
// Optional macro SPARSE_MATCH_CNT_EN adds match_cnt_o (accepted matches of
// the current/last job).
module sparse_match_sched
    import sparse_sched_pkg::*;
#(
    parameter  int SIZE      = 128,
    parameter  int NUM_CHUNK = 4,
    localparam int IDX_W     = idx_w(SIZE),
    localparam int CHK_W     = chk_w(NUM_CHUNK),
    localparam int CNT_W     = cnt_w(SIZE, NUM_CHUNK)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    flush_i,
    sparse_match_sched_if.slave     bus,
    output logic                    busy_o,
    output logic                    done_o
`ifdef SPARSE_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]        match_cnt_o
`endif
);
    sched_state_e     state_q, state_d;
    logic [CHK_W-1:0] chunk_idx_q, chunk_idx_d;
    logic [SIZE-1:0]  mask_q, mask_d;

    logic [IDX_W-1:0] lsb_idx;
    logic             lsb_any;
    logic             lsb_one;
    logic             in_scan;
    logic             last_chunk;
    logic             advance;

    sparse_lsb_find #(.SIZE(SIZE)) u_lsb (
        .vec_i (mask_q),
        .idx_o (lsb_idx),
        .any_o (lsb_any),
        .one_o (lsb_one)
    );

    assign in_scan    = (state_q == SCAN);
    assign last_chunk = (chunk_idx_q == CHK_W'(NUM_CHUNK - 1));

    always_comb begin
        state_d     = state_q;
        chunk_idx_d = chunk_idx_q;
        mask_d      = mask_q;
        advance     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = LOAD;
                    chunk_idx_d = '0;
                end
            end
            LOAD: begin
                if (bus.chunk_valid_i) begin
                    mask_d  = bus.in1_i & bus.in2_i;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!lsb_any) begin
                    advance = 1'b1;
                end else if (bus.match_ready_i) begin
                    mask_d  = mask_q & (mask_q - SIZE'(1));
                    advance = lsb_one;
                end
                if (advance) begin
                    if (last_chunk) begin
                        state_d = DONE;
                    end else begin
                        chunk_idx_d = chunk_idx_q + CHK_W'(1);
                        state_d     = LOAD;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d     = IDLE;
            chunk_idx_d = '0;
            mask_d      = '0;
        end
    end

`ifdef SPARSE_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (flush_i || (state_q == IDLE && start_i)) begin
            cnt_d = '0;
        end else if (in_scan && lsb_any && bus.match_ready_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign match_cnt_o = cnt_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            chunk_idx_q <= '0;
            mask_q      <= '0;
`ifdef SPARSE_MATCH_CNT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            chunk_idx_q <= chunk_idx_d;
            mask_q      <= mask_d;
`ifdef SPARSE_MATCH_CNT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Outputs decode registered state only, so they never depend on inputs.
    assign busy_o            = (state_q != IDLE);
    assign done_o            = (state_q == DONE);
    assign bus.chunk_ready_o = (state_q == LOAD);
    assign bus.match_valid_o = in_scan && lsb_any;
    assign bus.match_addr_o  = in_scan ? {chunk_idx_q, lsb_idx} : '0;
    assign bus.match_last_o  = in_scan && last_chunk && lsb_one;

endmodule

// File: tb/tb_sparse_match_sched.sv
module tb_sparse_match_sched;
    import sparse_sched_pkg::*;

    localparam int SZ   = 8;
    localparam int NC   = 2;
    localparam int MAXC = 256;
    localparam int CW   = cnt_w(SZ, NC);

    logic clk = 1'b0;
    logic rst_ni;
    logic start_i;
    logic flush_i;
    logic busy_o;
    logic done_o;
    logic [CW-1:0] match_cnt;

    sparse_match_sched_if #(.SIZE(SZ), .NUM_CHUNK(NC)) bus ();

    sparse_match_sched #(.SIZE(SZ), .NUM_CHUNK(NC)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .flush_i (flush_i),
        .bus     (bus),
        .busy_o  (busy_o),
        .done_o  (done_o)
`ifdef SPARSE_MATCH_CNT_EN
        ,
        .match_cnt_o (match_cnt)
`endif
    );

`ifndef SPARSE_MATCH_CNT_EN
    assign match_cnt = '0;
`endif

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Job description filled by the caller.
    logic [SZ-1:0] in1_a [NC];
    logic [SZ-1:0] in2_a [NC];
    int            dly_a [NC];
    bit            rdy_base [MAXC];

    // Per-cycle timeline of a job: cycle 0 is the start cycle (IDLE).
    bit            vin [MAXC];
    logic [SZ-1:0] din1 [MAXC];
    logic [SZ-1:0] din2 [MAXC];
    bit            rdy [MAXC];
    bit            exp_busy [MAXC];
    bit            exp_rdy [MAXC];
    bit            exp_valid [MAXC];
    bit            exp_last [MAXC];
    int            exp_addr [MAXC];
    int            exp_cnt [MAXC];
    int            cur_T;

    // Timeline: each chunk spends (delay+1) cycles waiting for its handshake,
    // then one empty scan cycle or one cycle per offered match (stalls repeat).
    task automatic build_timeline();
        int t, h, k, rem;
        logic [SZ-1:0] m;
        for (int i = 0; i < MAXC; i++) begin
            vin[i] = 1'($urandom % 2);
            din1[i] = SZ'($urandom);
            din2[i] = SZ'($urandom);
            rdy[i] = rdy_base[i];
            exp_busy[i] = 0; exp_rdy[i] = 0; exp_valid[i] = 0;
            exp_last[i] = 0; exp_addr[i] = 0; exp_cnt[i] = 0;
        end
        t = 1;
        for (int c = 0; c < NC; c++) begin
            for (int i = t; i < t + dly_a[c]; i++) begin
                exp_rdy[i] = 1;
                vin[i] = 0;
            end
            h = t + dly_a[c];
            exp_rdy[h] = 1;
            vin[h] = 1;
            din1[h] = in1_a[c];
            din2[h] = in2_a[c];
            m = in1_a[c] & in2_a[c];
            rem = $countones(m);
            k = h + 1;
            if (rem == 0) begin
                k = k + 1;
            end else begin
                for (int b = 0; b < SZ; b++) begin
                    if (m[b]) begin
                        do begin
                            exp_valid[k] = 1;
                            exp_addr[k] = c * SZ + b;
                            exp_last[k] = (c == NC - 1) && (rem == 1);
                            k++;
                        end while (!rdy[k-1]);
                        rem--;
                    end
                end
            end
            t = k;
        end
        cur_T = t;
        for (int i = 1; i <= cur_T; i++) exp_busy[i] = 1;
        for (int i = 1; i <= cur_T; i++)
            exp_cnt[i+1] = exp_cnt[i] + ((exp_valid[i] && rdy[i]) ? 1 : 0);
    endtask

    task automatic check_cycle(input int k);
        check_eq("busy", 32'(busy_o), 32'(exp_busy[k]));
        check_eq("done", 32'(done_o), 32'(k == cur_T));
        check_eq("chunk_ready", 32'(bus.chunk_ready_o), 32'(exp_rdy[k]));
        check_eq("match_valid", 32'(bus.match_valid_o), 32'(exp_valid[k]));
        check_eq("match_last", 32'(bus.match_last_o), 32'(exp_last[k]));
        if (exp_valid[k]) check_eq("match_addr", 32'(bus.match_addr_o), 32'(exp_addr[k]));
`ifdef SPARSE_MATCH_CNT_EN
        if (k >= 1) check_eq("match_cnt", 32'(match_cnt), 32'(exp_cnt[k]));
`endif
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
        check_eq({tag, "_done"}, 32'(done_o), 32'd0);
        check_eq({tag, "_ready"}, 32'(bus.chunk_ready_o), 32'd0);
        check_eq({tag, "_valid"}, 32'(bus.match_valid_o), 32'd0);
        check_eq({tag, "_last"}, 32'(bus.match_last_o), 32'd0);
        check_eq({tag, "_addr"}, 32'(bus.match_addr_o), 32'd0);
`ifdef SPARSE_MATCH_CNT_EN
        check_eq({tag, "_cnt"}, 32'(match_cnt), 32'd0);
`endif
    endtask

    // mode: 0 full job, 1 flush at first offered match (ready=1),
    //       2 async reset at first offered match, 3 flush together with start.
    task automatic run_job(input int mode);
        int ab;
        build_timeline();
        ab = 0;
        if (mode == 1 || mode == 2) begin
            ab = 1;
            for (int i = MAXC - 1; i >= 1; i--) if (exp_valid[i]) ab = i;
            rdy[ab] = 1;
        end
        for (int k = 0; k <= cur_T + 1; k++) begin
            @(posedge clk); #1;
            start_i = (k == 0) ? 1'b1 : ((k <= cur_T) ? 1'($urandom % 2) : 1'b0);
            flush_i = (mode == 1 && k == ab) || (mode == 3 && k == 0);
            bus.chunk_valid_i = vin[k];
            bus.in1_i = din1[k];
            bus.in2_i = din2[k];
            bus.match_ready_i = rdy[k];
            @(negedge clk);
            check_cycle(k);
            if (mode != 0 && k == ab) begin
                if (mode == 2) begin
                    #2 rst_ni = 1'b0;
                    #1 check_idle("async_rst");
                    @(posedge clk); #1 rst_ni = 1'b1;
                end else begin
                    @(posedge clk); #1;
                end
                start_i = 1'b0;
                flush_i = 1'b0;
                @(negedge clk);
                check_idle("after_abort");
                return;
            end
        end
        start_i = 1'b0;
    endtask

    task automatic rand_job(input int density);
        for (int c = 0; c < NC; c++) begin
            in1_a[c] = SZ'($urandom);
            in2_a[c] = SZ'($urandom);
            if (density == 0) in2_a[c] = '0;
            if (density == 2) in2_a[c] = in1_a[c];
            dly_a[c] = int'($urandom_range(0, 3));
        end
        for (int i = 0; i < MAXC; i++) rdy_base[i] = (i >= 100) ? 1'b1 : ($urandom_range(0, 9) < 7);
    endtask

    task automatic all_ready();
        for (int i = 0; i < MAXC; i++) rdy_base[i] = 1'b1;
        for (int c = 0; c < NC; c++) dly_a[c] = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        start_i = 1'b0;
        flush_i = 1'b0;
        bus.chunk_valid_i = 1'b0;
        bus.in1_i = '0;
        bus.in2_i = '0;
        bus.match_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk); #1 rst_ni = 1'b1;

        // Addresses 4, 7, 8; last only on 8; count 3.
        all_ready();
        in1_a[0] = 8'h96; in2_a[0] = 8'hF0;
        in1_a[1] = 8'h01; in2_a[1] = 8'h01;
        run_job(0);

        // All chunks empty.
        all_ready();
        in1_a[0] = 8'h5A; in2_a[0] = 8'hA5;
        in1_a[1] = 8'hFF; in2_a[1] = 8'h00;
        run_job(0);

        // Backpressure: addr 2 held for 3 stall cycles.
        all_ready();
        in1_a[0] = 8'h0C; in2_a[0] = 8'h0C;
        in1_a[1] = 8'h00; in2_a[1] = 8'h00;
        rdy_base[2] = 0; rdy_base[3] = 0; rdy_base[4] = 0;
        run_job(0);

        // Chunk valid delayed 5 cycles in LOAD.
        all_ready();
        dly_a[0] = 5;
        in1_a[0] = 8'h81; in2_a[0] = 8'hC3;
        in1_a[1] = 8'h10; in2_a[1] = 8'h30;
        run_job(0);

        // Flush during scan, then a fresh job from chunk 0.
        all_ready();
        in1_a[0] = 8'hFF; in2_a[0] = 8'h6C;
        in1_a[1] = 8'h0F; in2_a[1] = 8'h0F;
        run_job(1);
        rand_job(2);
        run_job(0);

        // Flush wins over start in the same cycle.
        rand_job(1);
        run_job(3);

        // Async reset mid-scan, then a full job.
        all_ready();
        in1_a[0] = 8'h22; in2_a[0] = 8'h22;
        in1_a[1] = 8'h80; in2_a[1] = 8'h80;
        run_job(2);
        rand_job(1);
        run_job(0);

        for (int j = 0; j < 40; j++) begin
            rand_job(int'($urandom_range(0, 2)));
            run_job((j % 10 == 9) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sparse_match_sched.md
Name: sparse_match_sched

Overview:
- Job-level scheduler for the sparse IFM/filter bitmap match datapath.
- Accepts NUM_CHUNK bitmap chunk pairs per job over a valid/ready handshake and ANDs each pair.
- Emits each set bit of the AND result as a match address, lowest index first, one per cycle, under downstream backpressure.
- Sits between the bitmap fetch unit and the sparse MAC address generator; signals job completion.

Parameters:
- SIZE, 128, bitmap chunk width in bits (power of 2, >=4).
- NUM_CHUNK, 4, chunks per job (power of 2, >=2).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  job start pulse; ignored unless busy_o=0.
- flush_i  in  1  synchronous abort; returns the block to IDLE from any state.
- chunk_valid_i  in  1  chunk pair valid.
- chunk_ready_o  out  1  chunk pair accepted when valid&ready.
- in1_i  in  SIZE  IFM bitmap chunk.
- in2_i  in  SIZE  filter bitmap chunk.
- match_valid_o  out  1  match address valid.
- match_ready_i  in  1  downstream accepts the match.
- match_addr_o  out  CHK_W+IDX_W  {chunk_idx, bit index}.
- match_last_o  out  1  final match of the job; qualified by match_valid_o.
- busy_o  out  1  job in progress (state != IDLE).
- done_o  out  1  one-cycle job-complete pulse.

Behaviour:
- Widths: IDX_W=$clog2(SIZE); CHK_W=$clog2(NUM_CHUNK).
- Registers: state_r, chunk_idx_r (CHK_W), mask_r (SIZE).
- Reset (rst_ni=0, asynchronous):
  - state_r=IDLE; chunk_idx_r=0; mask_r=0.
  - All outputs 0; match_addr_o=0.
- FSM states: IDLE, LOAD, SCAN, DONE.
- IDLE:
  - chunk_ready_o=0.
  - start_i=1 -> LOAD, with chunk_idx_r<=0.
- LOAD:
  - chunk_ready_o=1.
  - On chunk_valid_i: mask_r<=in1_i&in2_i, then -> SCAN.
- SCAN, mask_r==0 (empty chunk):
  - One cycle with match_valid_o=0.
  - If chunk_idx_r==NUM_CHUNK-1 -> DONE; else chunk_idx_r++ and -> LOAD.
- SCAN, mask_r!=0:
  - match_valid_o=1; match_addr_o={chunk_idx_r, lowest set index of mask_r}.
  - On match_ready_i: clear that bit in mask_r.
  - If the remaining mask is zero after the clear: DONE if on the last chunk, else chunk_idx_r++ and -> LOAD.
  - Without match_ready_i: match_valid_o and match_addr_o are held stable; no state change.
- match_last_o=1 iff in SCAN, chunk_idx_r==NUM_CHUNK-1, and mask_r has exactly one set bit.
- DONE: done_o=1 for exactly one cycle, then -> IDLE.
- Latency:
  - First match_valid_o is one cycle after the chunk handshake.
  - Sustained rate is one match per cycle while match_ready_i=1.
  - Each chunk costs at least one LOAD cycle plus one SCAN cycle.
- Job with zero matches: no match_valid_o; done_o follows the last empty SCAN.
- start_i while busy_o=1: ignored.
- flush_i:
  - Has priority over every transition, including start_i in the same cycle.
  - Next state IDLE; mask_r=0, chunk_idx_r=0.
  - No done_o is produced.
  - An in-flight match is dropped even if match_ready_i=1 in that cycle.
- Reset mid-job: immediate return to reset values; no done_o.

Optional Feature:
- Macro: SPARSE_MATCH_CNT_EN.
- When defined:
  - Adds output match_cnt_o, width $clog2(SIZE*NUM_CHUNK+1).
  - Cleared on an accepted start_i; incremented per accepted match (valid&ready).
  - Holds its value after done_o until the next accepted start_i.
  - Reset to 0; cleared by flush_i.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package sparse_sched_pkg:
  - State enum sched_state_e {IDLE, LOAD, SCAN, DONE}.
  - Width helper functions for IDX_W, CHK_W and the count width.
- Sub-module sparse_lsb_find:
  - Parameterised SIZE, purely combinational.
  - Outputs the lowest set index, an any-set flag, and a single-set flag (used for match_last_o).

Test Plan:
- SIZE=8, NUM_CHUNK=2; chunk0 in1=0x96 in2=0xF0, chunk1 in1=0x01 in2=0x01; match_ready_i=1 -> addresses 4, 7, 8; match_last_o only on 8; done_o one cycle after 8 is accepted.
- All four chunks AND to zero (SIZE=128) -> no match_valid_o; done_o after 8 active cycles (4x LOAD+SCAN, chunk_valid_i always high).
- Backpressure: mask 0x0C, match_ready_i low for 3 cycles -> addr 2 held stable 3 cycles; then 2, 3 accepted in consecutive cycles.
- chunk_valid_i delayed 5 cycles in LOAD -> chunk_ready_o held high; no match_valid_o until the cycle after the handshake.
- flush_i during SCAN with match_ready_i=1 -> next cycle IDLE, busy_o=0, no done_o; a new start_i then begins at chunk 0.
- rst_ni asserted mid-SCAN -> all outputs 0 asynchronously; with SPARSE_MATCH_CNT_EN, the test-1 stimulus gives match_cnt_o=3 after done_o.
